// File: rtl/onehot_req_pkg.sv
// onehot_req_pkg: shared sizes and index/mask helpers for the one-hot request encoder and decoder.
package onehot_req_pkg;
  localparam int ONEHOT_N = 4;
  localparam int ONEHOT_W = $clog2(ONEHOT_N);
  function automatic logic [ONEHOT_W-1:0] lowest_set_idx(input logic [ONEHOT_N-1:0] vec);
    logic [ONEHOT_W-1:0] r;
    r = '0;
    for (int i = ONEHOT_N - 1; i >= 0; i--) if (vec[i]) r = ONEHOT_W'(i);
    return r;
  endfunction
  function automatic logic [ONEHOT_N-1:0] onehot(input logic [ONEHOT_W-1:0] idx);
    return ONEHOT_N'(1) << idx;
  endfunction
endpackage

// File: rtl/onehot_req_encoder_lsb_priority_pick.sv
// lsb_priority_pick: combinational lowest-set-bit picker returning index, one-hot mask and any.
module lsb_priority_pick
  import onehot_req_pkg::*;
#(
  parameter int N = ONEHOT_N,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] mask_o,
  output logic         any_o
);
  always_comb begin
    idx_o = '0;
    mask_o = '0;
    any_o = |vec_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = W'(i);
        mask_o = '0;
        mask_o[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/onehot_req_encoder.sv
// onehot_req_encoder: captures request bits and emits their indices lowest-first over valid/ready.
// Optional ONEHOT_REQ_ENCODER_COALESCE_CNT_EN adds a saturating count of requests hitting pending bits.
module onehot_req_encoder
  import onehot_req_pkg::*;
#(
  parameter int N = ONEHOT_N,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         flush,
  input  logic [N-1:0] req,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         busy
`ifdef ONEHOT_REQ_ENCODER_COALESCE_CNT_EN
  ,
  output logic [7:0]   coalesce_cnt
`endif
);
  logic [N-1:0] pending_q, pending_d, cap, pick_mask, mask;
  logic [W-1:0] out_idx_q, out_idx_d, idx;
  logic         out_valid_q, out_valid_d, load, any;

  lsb_priority_pick #(.N(N)) u_pick (
    .vec_i (pending_q),
    .idx_o (idx),
    .mask_o(mask),
    .any_o (any)
  );

  // A new request OR-ed in after the pick mask wins over the grant of the same bit.
  always_comb begin
    cap = en ? req : '0;
    load = !out_valid_q || out_ready;
    pick_mask = (load && any) ? mask : '0;
    pending_d = flush ? '0 : (pending_q & ~pick_mask) | cap;
    out_valid_d = flush ? 1'b0 : (load ? any : out_valid_q);
    out_idx_d = (!flush && load && any) ? idx : out_idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      out_idx_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      out_idx_q <= out_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ONEHOT_REQ_ENCODER_COALESCE_CNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       hit;
  always_comb begin
    hit = |(cap & pending_q & ~pick_mask);
    cnt_d = flush ? 8'h00 : ((hit && cnt_q != 8'hFF) ? cnt_q + 8'h01 : cnt_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'h00;
    else cnt_q <= cnt_d;
  end
  assign coalesce_cnt = cnt_q;
`endif

  assign out_idx = out_idx_q;
  assign out_valid = out_valid_q;
  assign pending = pending_q;
  assign busy = (|pending_q) | out_valid_q;
endmodule

// File: tb/tb_onehot_req_encoder.sv
// tb_onehot_req_encoder: directed self-checking bench for onehot_req_encoder.
module tb_onehot_req_encoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] req = '0;
  logic [1:0] out_idx;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] pending;
  logic       busy;
  int         checks = 0;
  int         failures = 0;
`ifdef ONEHOT_REQ_ENCODER_COALESCE_CNT_EN
  logic [7:0] coalesce_cnt;
`endif

  onehot_req_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .flush    (flush),
    .req      (req),
    .out_idx  (out_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pending  (pending),
    .busy     (busy)
`ifdef ONEHOT_REQ_ENCODER_COALESCE_CNT_EN
    ,
    .coalesce_cnt(coalesce_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pending", 32'(pending), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_idx", 32'(out_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_valid", 32'(out_valid), 0);

    en = 1'b1; req = 4'b1010; out_ready = 1'b1;
    tick();
    chk("t1_pending", 32'(pending), 32'b1010);
    chk("t1_valid0", 32'(out_valid), 0);
    req = '0;
    tick();
    chk("t1_idx1", 32'(out_idx), 1);
    chk("t1_valid1", 32'(out_valid), 1);
    tick();
    chk("t1_idx3", 32'(out_idx), 3);
    chk("t1_valid3", 32'(out_valid), 1);
    tick();
    chk("t1_drain_valid", 32'(out_valid), 0);
    chk("t1_drain_idx", 32'(out_idx), 3);
    chk("t1_drain_busy", 32'(busy), 0);

    req = 4'b1111; out_ready = 1'b0;
    tick();
    chk("t2_pending", 32'(pending), 32'b1111);
    req = '0;
    tick();
    chk("t2_first_idx", 32'(out_idx), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_stall_idx", 32'(out_idx), 0);
      chk("t2_stall_valid", 32'(out_valid), 1);
    end
    chk("t2_stall_pending", 32'(pending), 32'b1110);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t2_seq_idx", 32'(out_idx), 32'(i));
      chk("t2_seq_valid", 32'(out_valid), 1);
    end
    tick();
    chk("t2_end_valid", 32'(out_valid), 0);

    en = 1'b0; req = 4'b0100;
    tick();
    tick();
    chk("t3_pending", 32'(pending), 0);
    chk("t3_valid", 32'(out_valid), 0);

    en = 1'b1;
    tick();
    chk("t4_pending", 32'(pending), 32'b0100);
    tick();
    chk("t4_idx", 32'(out_idx), 2);
    chk("t4_keep_pending", 32'(pending), 32'b0100);
    req = '0;
    tick();
    chk("t4_regrant_idx", 32'(out_idx), 2);
    chk("t4_regrant_valid", 32'(out_valid), 1);
    chk("t4_regrant_pending", 32'(pending), 0);
    tick();
    chk("t4_end_valid", 32'(out_valid), 0);

    req = 4'b0111; out_ready = 1'b0;
    tick();
    req = '0;
    tick();
    chk("t5_pending", 32'(pending), 32'b0110);
    chk("t5_valid", 32'(out_valid), 1);
    flush = 1'b1; req = 4'b0001;
    tick();
    chk("t5_flush_pending", 32'(pending), 0);
    chk("t5_flush_valid", 32'(out_valid), 0);
    flush = 1'b0; req = '0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_idx0", 32'(out_valid), 0);
    end

`ifdef ONEHOT_REQ_ENCODER_COALESCE_CNT_EN
    chk("t6_cnt_start", 32'(coalesce_cnt), 0);
    req = 4'b1000; out_ready = 1'b0;
    tick();
    tick();
    chk("t6_cnt_after_pick", 32'(coalesce_cnt), 0);
    tick();
    chk("t6_cnt_first_hit", 32'(coalesce_cnt), 1);
    for (int i = 0; i < 297; i++) tick();
    chk("t6_cnt_sat", 32'(coalesce_cnt), 32'hFF);
    chk("t6_stall_idx", 32'(out_idx), 3);
    req = '0; out_ready = 1'b1;
    tick();
    chk("t6_regrant_idx", 32'(out_idx), 3);
    chk("t6_regrant_pending", 32'(pending), 0);
    tick();
    chk("t6_end_valid", 32'(out_valid), 0);
    chk("t6_cnt_hold", 32'(coalesce_cnt), 32'hFF);
`endif

    req = 4'b1111; out_ready = 1'b0;
    tick();
    req = '0;
    tick();
    chk("t7_pre_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_pending", 32'(pending), 0);
    chk("t7_rst_valid", 32'(out_valid), 0);
    chk("t7_rst_idx", 32'(out_idx), 0);
    chk("t7_rst_busy", 32'(busy), 0);
`ifdef ONEHOT_REQ_ENCODER_COALESCE_CNT_EN
    chk("t7_rst_cnt", 32'(coalesce_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t7_release_valid", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/onehot_req_encoder.md
Name: onehot_req_encoder

Overview:
- Sequential one-hot/multi-hot to binary encoder; the inverse direction of the team's 2-to-4 enable-gated one-hot decoder.
- Captures request bits into a pending register, then emits one binary index at a time, lowest index first, over a valid/ready handshake.
- Sits between decoded select/request lines and a consumer that accepts a binary index.

Parameters:
- N, 4, number of request lines (N >= 2).
- W, $clog2(N), index width (2 at default); derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; when low, req is ignored.
- flush  input  1  synchronous clear of pending and output stage.
- req  input  N  request vector; any number of bits may be set.
- out_idx  output  W  binary index of the granted request.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts out_idx.
- pending  output  N  registered pending-request vector.
- busy  output  1  (pending != 0) | out_valid.

Behaviour:
- Reset (rst_n low, asynchronous): pending=0, out_valid=0, out_idx=0, busy=0. Release is synchronous to clk and produces no spurious output.
- Capture: on each edge, pending <= (pending & ~pick_mask) | (en ? req : 0).
  - Re-requesting a bit that is already pending coalesces into one grant.
- Load condition: load = !out_valid | (out_valid & out_ready).
- Pick: when load is true and pending != 0:
  - Choose the lowest set bit k of the current (registered) pending.
  - out_idx <= k, out_valid <= 1, pick_mask = onehot(k).
  - Otherwise pick_mask = 0.
- Drain: when load is true and pending == 0, out_valid <= 0 and out_idx holds its last value.
- Latency: req sampled at edge t sets pending at t; out_valid is asserted at edge t+1 at the earliest.
- Throughput: one index per cycle while out_ready=1 and pending is non-empty.
- Stall: while out_valid & !out_ready, out_idx and out_valid hold stable; capture continues.
- Simultaneous pick and new req on the same bit k: the new request wins. Bit k stays set in pending, so k is granted again later.
- en=0: capture is blocked; pending continues to drain normally.
- flush=1: pending <= 0 and out_valid <= 0 on that edge. flush has priority over capture, pick and handshake, and the req of the same cycle is discarded.
- Reset asserted mid-transfer clears everything immediately. The consumer must treat the index as not transferred.
- No combinational path from req to any output. The only input-to-output effect is via out_ready into the load condition (registered).
- State view (derived, not a separate FSM register):
  - IDLE: pending=0, !out_valid.
  - PEND: pending!=0, !out_valid.
  - OUT: out_valid.
  - IDLE->PEND on capture; PEND->OUT next edge; OUT->OUT on accept with pending non-empty; OUT->IDLE on accept with pending empty.

Optional Feature:
- Macro: ONEHOT_REQ_ENCODER_COALESCE_CNT_EN.
- Defined: adds output coalesce_cnt [7:0].
  - Increments by 1 on each edge where (en ? req : 0) & pending & ~pick_mask != 0, i.e. a request hit an already-pending bit.
  - One increment per cycle regardless of how many bits collided.
  - Saturates at 8'hFF. Cleared by rst_n and by flush.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package onehot_req_pkg holds:
  - the default N and W constants;
  - a function lowest_set_idx(vec) returning the W-bit index;
  - a function onehot(idx) returning the N-bit mask.
  - The team's decoder can reuse onehot().
- One natural sub-module: lsb_priority_pick, purely combinational.
  - Takes the pending vector.
  - Produces idx, mask and any.
  - The top level holds all registers and the handshake.

Test Plan:
- Reset, then req=4'b1010 with en=1 for 1 cycle, out_ready=1 -> pending=1010. Next edge out_idx=1, valid=1; then out_idx=3; then out_valid=0, busy=0.
- req=4'b1111, out_ready=0 for 5 cycles, then 1 -> out_idx=0 held stable while stalled; then indices 0,1,2,3 on consecutive cycles.
- en=0, req=4'b0100 -> pending stays 0, out_valid stays 0.
- out_idx=2 being accepted in the same cycle as req=4'b0100 -> pending bit 2 remains set; index 2 is emitted again later.
- Pending=4'b0110 with out_valid=1; assert flush with req=4'b0001 -> next edge pending=0, out_valid=0; index 0 never appears.
- With ONEHOT_REQ_ENCODER_COALESCE_CNT_EN: hold req=4'b1000, out_ready=0 for 300 cycles -> coalesce_cnt saturates at 8'hFF and index 3 is granted once after release; assert rst_n=0 mid-stream -> all outputs 0 immediately.
